// File: rtl/regfile_wb_divider.sv
// -----------------------------------------------------------------------------
// regfile_wb_divider
// Iterative RV32M divide/remainder unit on the execute-to-writeback path.
// Radix-2 restoring division, one quotient bit per clock. Handles DIV, DIVU,
// REM and REMU, including the RISC-V divide-by-zero and signed-overflow cases.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   start_i     request a new division (accepted only while busy_o=0)
//   op_i        00=DIV 01=DIVU 10=REM 11=REMU (sampled with start_i)
//   rs1_data_i  dividend (sampled with start_i)
//   rs2_data_i  divisor  (sampled with start_i)
//   rd_addr_i   destination register (sampled with start_i)
//   kill_i      pipeline flush, aborts any operation
//   busy_o      high whenever the unit is not idle
//   done_o      one-cycle result-valid pulse
//   rd_addr_o   destination register of the finished operation
//   rd_data_o   quotient or remainder
//   rd_wren_o   register-file write enable (done_o with rd_addr_o != 0)
// -----------------------------------------------------------------------------
module regfile_wb_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   input  logic [4:0]       rd_addr_i,
   input  logic             kill_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [4:0]       rd_addr_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_wren_o
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t            r_state, w_state_next;
   logic [1:0]        r_op, w_op_next;
   logic [CW-1:0]     r_cnt, w_cnt_next;
   logic [WIDTH-1:0]  r_rem, w_rem_next;
   logic [WIDTH-1:0]  r_quo, w_quo_next;
   logic [WIDTH-1:0]  r_div, w_div_next;
   logic              r_qneg, w_qneg_next;
   logic              r_rneg, w_rneg_next;
   logic [4:0]        r_addr, w_addr_next;
   logic              r_busy, w_busy_next;
   logic              r_done, w_done_next;
   logic              r_wren, w_wren_next;
   logic [4:0]        r_rd_addr, w_rd_addr_next;
   logic [WIDTH-1:0]  r_rd_data, w_rd_data_next;

   // Operand decode at the start request
   logic              w_accept;
   logic              w_signed_in;
   logic              w_div0;
   logic              w_ovf;
   logic [WIDTH-1:0]  w_rs1_abs;
   logic [WIDTH-1:0]  w_rs2_abs;

   // One restoring step: {rem,quo} << 1, then trial subtract. The shifted
   // remainder needs WIDTH+1 bits; one more bit holds the borrow.
   logic [WIDTH:0]    w_sh;
   logic [WIDTH+1:0]  w_diff;
   logic              w_neg;

   // Result selection and sign fix-up
   logic [WIDTH-1:0]  w_fix_sel;
   logic              w_fix_neg;
   logic [WIDTH-1:0]  w_fix_val;

   always_comb begin
      w_accept    = start_i & ~kill_i;
      w_signed_in = ~op_i[0];
      w_div0      = (rs2_data_i == '0);
      w_ovf       = w_signed_in && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
      w_rs1_abs   = (w_signed_in && rs1_data_i[WIDTH-1]) ? -rs1_data_i : rs1_data_i;
      w_rs2_abs   = (w_signed_in && rs2_data_i[WIDTH-1]) ? -rs2_data_i : rs2_data_i;

      w_sh   = {r_rem, r_quo[WIDTH-1]};
      w_diff = {1'b0, w_sh} - {2'b00, r_div};
      w_neg  = w_diff[WIDTH+1];

      w_fix_sel = r_op[1] ? r_rem : r_quo;
      w_fix_neg = ~r_op[0] & (r_op[1] ? r_rneg : r_qneg);
      w_fix_val = w_fix_neg ? -w_fix_sel : w_fix_sel;
   end

   always_comb begin
      w_state_next   = r_state;
      w_op_next      = r_op;
      w_cnt_next     = r_cnt;
      w_rem_next     = r_rem;
      w_quo_next     = r_quo;
      w_div_next     = r_div;
      w_qneg_next    = r_qneg;
      w_rneg_next    = r_rneg;
      w_addr_next    = r_addr;
      w_rd_addr_next = r_rd_addr;
      w_rd_data_next = r_rd_data;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_op_next   = op_i;
               w_addr_next = rd_addr_i;
               w_qneg_next = rs1_data_i[WIDTH-1] ^ rs2_data_i[WIDTH-1];
               w_rneg_next = rs1_data_i[WIDTH-1];
               if (w_div0) begin
                  w_state_next   = S_DONE;
                  w_rd_addr_next = rd_addr_i;
                  w_rd_data_next = op_i[1] ? rs1_data_i : '1;
               end else if (w_ovf) begin
                  w_state_next   = S_DONE;
                  w_rd_addr_next = rd_addr_i;
                  w_rd_data_next = op_i[1] ? '0 : MIN_NEG;
               end else begin
                  w_state_next = S_CALC;
                  w_cnt_next   = CW'(WIDTH - 1);
                  w_rem_next   = '0;
                  w_quo_next   = w_rs1_abs;
                  w_div_next   = w_rs2_abs;
               end
            end
         end
         S_CALC: begin
            w_rem_next = w_neg ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], ~w_neg};
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == '0) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            w_state_next   = S_DONE;
            w_rd_addr_next = r_addr;
            w_rd_data_next = w_fix_val;
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Flush overrides everything; the visible result registers keep their
      // previous contents so an aborted op leaves no trace on the write port.
      if (kill_i) begin
         w_state_next   = S_IDLE;
         w_rd_addr_next = r_rd_addr;
         w_rd_data_next = r_rd_data;
      end

      // Status outputs are registered from the next state so they line up
      // exactly with the state they describe.
      w_busy_next = (w_state_next != S_IDLE);
      w_done_next = (w_state_next == S_DONE);
      w_wren_next = (w_state_next == S_DONE) && (w_rd_addr_next != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_addr    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wren    <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_next;
         r_op      <= w_op_next;
         r_cnt     <= w_cnt_next;
         r_rem     <= w_rem_next;
         r_quo     <= w_quo_next;
         r_div     <= w_div_next;
         r_qneg    <= w_qneg_next;
         r_rneg    <= w_rneg_next;
         r_addr    <= w_addr_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_wren    <= w_wren_next;
         r_rd_addr <= w_rd_addr_next;
         r_rd_data <= w_rd_data_next;
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign rd_wren_o = r_wren;
   assign rd_addr_o = r_rd_addr;
   assign rd_data_o = r_rd_data;

endmodule
